// File: rtl/mux_arbiter_pkg.sv
// Shared encodings for the two-requester mux arbiter.
package mux_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_GNT0 = 2'd1;
    localparam logic [1:0] ARB_GNT1 = 2'd2;

    localparam logic ARB_REQ0 = 1'b0;
    localparam logic ARB_REQ1 = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = ARB_IDLE,
        S_GNT0 = ARB_GNT0,
        S_GNT1 = ARB_GNT1
    } arb_state_e;

    // Requester 0 wins when alone, or when both ask and 1 was served last.
    function automatic logic pick_req0(input logic req0, input logic req1, input logic last);
        return req0 && (!req1 || (last == ARB_REQ1));
    endfunction

endpackage

// File: rtl/mux_arbiter_if.sv
// Requester/port bundle between two bus masters and the arbiter.
interface mux_arbiter_if #(
    parameter int unsigned WIDTH = 16
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic             gnt0;
    logic             gnt1;
    logic             sel;
    logic             busy;
    logic [WIDTH-1:0] data_out;

    modport master (
        output req0, req1, data0, data1,
        input  gnt0, gnt1, sel, busy, data_out
    );

    modport slave (
        input  req0, req1, data0, data1,
        output gnt0, gnt1, sel, busy, data_out
    );
endinterface

// File: rtl/mux_arbiter_mux.sv
// WIDTH-wide 2:1 mux built from 1-bit mux gates sharing one select.
module mux_gate (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);
    assign y = sel ? b : a;
endmodule

module g_mux_bus #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mux_gate u_mux (
            .a  (a[i]),
            .b  (b[i]),
            .sel(sel),
            .y  (y[i])
        );
    end
endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter owning the select of a shared 2:1 data mux.
// Optional hold-limit preemption is enabled by defining MUX_ARB_TIMEOUT_EN.
module mux_arbiter
    import mux_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic         clk,
    input  logic         reset,
    mux_arbiter_if.slave bus
);

    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("MAX_HOLD must be at least 1");
    end

    arb_state_e state_q, state_d;
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;
    logic       sel_q, sel_d;
    logic       busy_q, busy_d;
    logic       last_q, last_d;
    logic       expire_c;

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts grant cycles; cleared in IDLE so every grant starts at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(MAX_HOLD)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expire_c = (cnt_q == CNT_W'(MAX_HOLD - 1));
`else
    assign expire_c = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        unique case (state_q)
            S_IDLE: begin
                if (pick_req0(bus.req0, bus.req1, last_q)) begin
                    state_d = S_GNT0;
                    sel_d   = ARB_REQ0;
                    last_d  = ARB_REQ0;
                end else if (bus.req1) begin
                    state_d = S_GNT1;
                    sel_d   = ARB_REQ1;
                    last_d  = ARB_REQ1;
                end
            end
            // Handover always passes through IDLE for one turnaround cycle.
            S_GNT0: if (!bus.req0 || (expire_c && bus.req1)) state_d = S_IDLE;
            S_GNT1: if (!bus.req1 || (expire_c && bus.req0)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        gnt0_d = (state_d == S_GNT0);
        gnt1_d = (state_d == S_GNT1);
        busy_d = gnt0_d | gnt1_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            sel_q   <= ARB_REQ0;
            busy_q  <= 1'b0;
            last_q  <= ARB_REQ1;
        end else begin
            state_q <= state_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
        end
    end

    assign bus.gnt0 = gnt0_q;
    assign bus.gnt1 = gnt1_q;
    assign bus.sel  = sel_q;
    assign bus.busy = busy_q;

    g_mux_bus #(.WIDTH(WIDTH)) u_mux_bus (
        .a  (bus.data0),
        .b  (bus.data1),
        .sel(sel_q),
        .y  (bus.data_out)
    );

endmodule

// File: tb/tb_mux_arbiter.sv
// Scoreboard bench for mux_arbiter: directed per-cycle vectors, decoupled monitor.
module tb_mux_arbiter;

    localparam int unsigned WIDTH    = 16;
    localparam int unsigned MAX_HOLD = 4;

    typedef struct {
        logic             g0;
        logic             g1;
        logic             sel;
        logic             busy;
        logic [WIDTH-1:0] dout;
        int               id;
    } exp_t;

    logic clk;
    logic reset;
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;

    mux_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mux_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: apply inputs and queue the outputs expected during this cycle.
    task automatic cyc(input logic rst, input logic r0, input logic r1,
                       input logic eg0, input logic eg1, input logic esel);
        exp_t e;
        logic [WIDTH-1:0] d0;
        logic [WIDTH-1:0] d1;
        d0 = 16'hA5A5 ^ WIDTH'(vec_id * 16'h0111);
        d1 = 16'h5A5A ^ WIDTH'(vec_id * 16'h0203);
        reset     = rst;
        bus.req0  = r0;
        bus.req1  = r1;
        bus.data0 = d0;
        bus.data1 = d1;
        e.g0   = eg0;
        e.g1   = eg1;
        e.sel  = esel;
        e.busy = eg0 | eg1;
        e.dout = esel ? d1 : d0;
        e.id   = vec_id;
        exp_q.push_back(e);
        vec_id++;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares at mid-cycle, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.gnt0 !== e.g0 || bus.gnt1 !== e.g1 || bus.sel !== e.sel ||
                    bus.busy !== e.busy || bus.data_out !== e.dout) begin
                    errors++;
                    $display("FAIL vec%0d: got gnt0=%b gnt1=%b sel=%b busy=%b dout=%h, want gnt0=%b gnt1=%b sel=%b busy=%b dout=%h",
                             e.id, bus.gnt0, bus.gnt1, bus.sel, bus.busy, bus.data_out,
                             e.g0, e.g1, e.sel, e.busy, e.dout);
                end
                checks++;
                if ((bus.gnt0 & bus.gnt1) !== 1'b0) begin
                    errors++;
                    $display("FAIL excl vec%0d: gnt0=%b gnt1=%b, want not both high",
                             e.id, bus.gnt0, bus.gnt1);
                end
            end
        end
    end

    initial begin
        int pat;
        int waited;
        reset     = 1'b1;
        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        bus.data0 = '0;
        bus.data1 = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        cyc(1, 0, 0, 0, 0, 0);

        // Single requester: req0 for 5 cycles -> gnt0 for 5 cycles, one cycle later
        cyc(0, 1, 0, 0, 0, 0);
        repeat (4) cyc(0, 1, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Contention handover after reset (last=1 -> requester 0 first)
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        repeat (3) cyc(0, 1, 1, 1, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 1, 1);
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 1);

        // Round-robin: grants alternate 0,1,0,1 with 2-cycle holds
        cyc(0, 1, 1, 0, 0, 1);
        cyc(0, 1, 1, 1, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 1, 1);
        cyc(0, 1, 0, 0, 1, 1);
        cyc(0, 1, 1, 0, 0, 1);
        cyc(0, 1, 1, 1, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 1, 1);
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 1);

        // Reset mid-grant in GNT1, then contention grants requester 0 first
        cyc(0, 0, 1, 0, 0, 1);
        cyc(0, 0, 1, 0, 1, 1);
        cyc(1, 0, 1, 0, 1, 1);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Both requests held permanently
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 15; i++) begin
`ifdef MUX_ARB_TIMEOUT_EN
            pat = i % 10;
            if (pat < 4)       cyc(i == 14, 1, 1, 1, 0, 0);
            else if (pat == 4) cyc(i == 14, 1, 1, 0, 0, 0);
            else if (pat < 9)  cyc(i == 14, 1, 1, 0, 1, 1);
            else               cyc(i == 14, 1, 1, 0, 0, 1);
`else
            pat = i;
            cyc(i == 14, 1, 1, 1, 0, 0);
`endif
        end
        cyc(0, 0, 0, 0, 0, 0);

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
